circle_controller: RTL and testbench

CIRCLE_CONTROLLER -- requirements
Module: circle_controller

---
 rtl/circle_controller.sv | 125 ++++++++++++
 tb/tb_circle_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_controller.sv
// rtl/circle_controller.sv - circle point sequencer: issues NUM_POINTS fetches per reference pixel
// and tracks the matching register writes through a READ_LATENCY-deep valid/index pipeline.
module circle_controller #(
    parameter int NUM_POINTS   = 16,
    parameter int IDX_W        = 4,
    parameter int ADDR_W       = 15,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] refAddr,
    output logic [ADDR_W-1:0] curRef,
    output logic [IDX_W-1:0]  adjNumber,
    output logic              adjValid,
    output logic [IDX_W-1:0]  regAddr,
    output logic              regWrite,
    output logic              matReaden,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_ref;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_adj_valid;
    logic              r_mat_readen;
    logic              r_busy;
    logic              r_pipe_v   [READ_LATENCY];
    logic [IDX_W-1:0]  r_pipe_idx [READ_LATENCY];

    logic w_last_issue;
    logic w_last_write;

    assign w_last_issue = (r_cnt == LAST_IDX);
    assign w_last_write = r_pipe_v[READ_LATENCY-1] &&
                          (r_pipe_idx[READ_LATENCY-1] == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur_ref    <= '0;
            r_cnt        <= '0;
            r_adj_valid  <= 1'b0;
            r_mat_readen <= 1'b0;
            r_busy       <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_v[i]   <= 1'b0;
                r_pipe_idx[i] <= '0;
            end
        end else if (abort && (r_state != S_IDLE)) begin
            // Flushing the pipeline here is what suppresses the remaining writes.
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_adj_valid  <= 1'b0;
            r_mat_readen <= 1'b0;
            r_busy       <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_v[i]   <= 1'b0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_v[0]   <= r_adj_valid;
            r_pipe_idx[0] <= r_adj_valid ? r_cnt : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
            r_mat_readen <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state     <= S_ISSUE;
                        r_cur_ref   <= refAddr;
                        r_cnt       <= '0;
                        r_adj_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Counter parks at the last point and is cleared on exit, so it never wraps.
                    if (w_last_issue) begin
                        r_state     <= S_DRAIN;
                        r_cnt       <= '0;
                        r_adj_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_write) begin
                        r_state      <= S_DONE;
                        r_mat_readen <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign curRef    = r_cur_ref;
    assign adjNumber = r_cnt;
    assign adjValid  = r_adj_valid;
    assign regAddr   = r_pipe_idx[READ_LATENCY-1];
    assign regWrite  = r_pipe_v[READ_LATENCY-1];
    assign matReaden = r_mat_readen;
    assign busy      = r_busy;

endmodule

// File: tb/tb_circle_controller.sv
// tb/tb_circle_controller.sv - self-checking bench for circle_controller (default and N=8/L=1 instances)
module tb_circle_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        st [2];
    logic        ab [2];
    logic        rs [2];
    logic [14:0] ra [2];

    logic [14:0] o_cr [2];
    logic [3:0]  o_an [2];
    logic        o_av [2];
    logic [3:0]  o_ra [2];
    logic        o_rw [2];
    logic        o_mr [2];
    logic        o_bz [2];

    int checks = 0;
    int errors = 0;

    int np [2] = '{16, 8};
    int lt [2] = '{2, 1};

    bit m_act [2];
    int m_k   [2];
    int m_cur [2];

    typedef struct {
        int k;
        bit av;
        int an;
        bit rw;
        int ra;
        bit mr;
        bit bz;
        int cr;
    } vec_t;

    vec_t tbl [9];

    circle_controller u_dut0 (
        .clock(clock), .reset(rs[0]), .start(st[0]), .abort(ab[0]), .refAddr(ra[0]),
        .curRef(o_cr[0]), .adjNumber(o_an[0]), .adjValid(o_av[0]), .regAddr(o_ra[0]),
        .regWrite(o_rw[0]), .matReaden(o_mr[0]), .busy(o_bz[0])
    );

    circle_controller #(.NUM_POINTS(8), .READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(rs[1]), .start(st[1]), .abort(ab[1]), .refAddr(ra[1]),
        .curRef(o_cr[1]), .adjNumber(o_an[1]), .adjValid(o_av[1]), .regAddr(o_ra[1]),
        .regWrite(o_rw[1]), .matReaden(o_mr[1]), .busy(o_bz[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: the model follows the sequencing rules, then every output is compared.
    task automatic tick();
        bit av, rw, mr;
        int an, rad;
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rs[d]) begin
                m_act[d] = 0;
                m_cur[d] = 0;
            end else if (m_act[d]) begin
                if (ab[d]) m_act[d] = 0;
                else begin
                    m_k[d]++;
                    if (m_k[d] > np[d] + lt[d] + 1) m_act[d] = 0;
                end
            end else if (st[d] && !ab[d]) begin
                m_act[d] = 1;
                m_k[d]   = 1;
                m_cur[d] = int'(ra[d]);
            end
            av  = m_act[d] && (m_k[d] <= np[d]);
            an  = av ? m_k[d] - 1 : 0;
            rw  = m_act[d] && (m_k[d] >= lt[d] + 1) && (m_k[d] <= np[d] + lt[d]);
            rad = rw ? m_k[d] - 1 - lt[d] : 0;
            mr  = m_act[d] && (m_k[d] == np[d] + lt[d] + 1);
            check($sformatf("model_adjValid[%0d]", d),  o_av[d], av);
            check($sformatf("model_adjNumber[%0d]", d), o_an[d], an);
            check($sformatf("model_regWrite[%0d]", d),  o_rw[d], rw);
            check($sformatf("model_regAddr[%0d]", d),   o_ra[d], rad);
            check($sformatf("model_matReaden[%0d]", d), o_mr[d], mr);
            check($sformatf("model_busy[%0d]", d),      o_bz[d], m_act[d]);
            check($sformatf("model_curRef[%0d]", d),    o_cr[d], m_cur[d]);
        end
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            ab[d] = 1'b0;
            rs[d] = 1'b0;
        end
    endtask

    initial begin
        int rw_first, rw_last, rw_n, mr_c, mr_n, bz_n;

        tbl[0] = '{1,  1, 0,  0, 0,  0, 1, 'h1234};
        tbl[1] = '{2,  1, 1,  0, 0,  0, 1, 'h1234};
        tbl[2] = '{3,  1, 2,  1, 0,  0, 1, 'h1234};
        tbl[3] = '{16, 1, 15, 1, 13, 0, 1, 'h1234};
        tbl[4] = '{17, 0, 0,  1, 14, 0, 1, 'h1234};
        tbl[5] = '{18, 0, 0,  1, 15, 0, 1, 'h1234};
        tbl[6] = '{19, 0, 0,  0, 0,  1, 1, 'h1234};
        tbl[7] = '{20, 0, 0,  0, 0,  0, 0, 'h1234};
        tbl[8] = '{2,  1, 1,  0, 0,  0, 1, 'h1234};

        for (int d = 0; d < 2; d++) begin
            st[d] = 0; ab[d] = 0; rs[d] = 0; ra[d] = '0;
            m_act[d] = 0; m_k[d] = 0; m_cur[d] = 0;
        end

        // Reset state
        rs[0] = 1; rs[1] = 1; st[0] = 1; ra[0] = 15'h7fff;
        tick();
        check("reset_curRef", o_cr[0], 0);
        check("reset_busy", o_bz[0], 0);
        check("reset_adjValid", o_av[0], 0);
        check("reset_regWrite", o_rw[0], 0);
        tick();

        // Default sequence against the timing table
        st[0] = 1; ra[0] = 15'h1234;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int e = 0; e < 9; e++) begin
                if (tbl[e].k == c) begin
                    check($sformatf("tbl_adjValid_c%0d", c),  o_av[0], tbl[e].av);
                    check($sformatf("tbl_adjNumber_c%0d", c), o_an[0], tbl[e].an);
                    check($sformatf("tbl_regWrite_c%0d", c),  o_rw[0], tbl[e].rw);
                    check($sformatf("tbl_regAddr_c%0d", c),   o_ra[0], tbl[e].ra);
                    check($sformatf("tbl_matReaden_c%0d", c), o_mr[0], tbl[e].mr);
                    check($sformatf("tbl_busy_c%0d", c),      o_bz[0], tbl[e].bz);
                    check($sformatf("tbl_curRef_c%0d", c),    o_cr[0], tbl[e].cr);
                end
            end
        end

        // N=8, L=1 instance timing
        st[1] = 1; ra[1] = 15'h0777;
        rw_first = -1; rw_last = -1; rw_n = 0; mr_c = -1; mr_n = 0; bz_n = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (o_rw[1]) begin
                if (rw_first < 0) rw_first = c;
                rw_last = c;
                rw_n++;
            end
            if (o_mr[1]) begin mr_c = c; mr_n++; end
            if (o_bz[1]) bz_n++;
        end
        check("n8_rw_first", rw_first, 2);
        check("n8_rw_last", rw_last, 9);
        check("n8_rw_count", rw_n, 8);
        check("n8_mr_cycle", mr_c, 10);
        check("n8_mr_count", mr_n, 1);
        check("n8_busy_count", bz_n, 10);

        // Starts while busy (ISSUE and DONE) are ignored; first start in IDLE is taken
        st[0] = 1; ra[0] = 15'h1234;
        tick();
        for (int e = 1; e <= 20; e++) begin
            if (e == 5 || e == 19 || e == 20) begin st[0] = 1; ra[0] = 15'h0042; end
            tick();
            if (e + 1 == 6)  check("busy_start_curRef", o_cr[0], 'h1234);
            if (e + 1 == 20) begin
                check("done_start_curRef", o_cr[0], 'h1234);
                check("done_start_busy", o_bz[0], 0);
            end
            if (e + 1 == 21) begin
                check("idle_start_curRef", o_cr[0], 'h0042);
                check("idle_start_busy", o_bz[0], 1);
            end
        end
        repeat (20) tick();

        // Abort at cycle 8
        st[0] = 1; ra[0] = 15'h1234;
        tick();
        rw_n = 0; mr_n = 0;
        for (int e = 1; e <= 25; e++) begin
            if (e == 8) ab[0] = 1;
            tick();
            if (e + 1 >= 9) begin
                if (o_rw[0]) rw_n++;
                if (o_mr[0]) mr_n++;
            end
            if (e + 1 == 9) begin
                check("abort_busy", o_bz[0], 0);
                check("abort_adjValid", o_av[0], 0);
            end
        end
        check("abort_rw_after", rw_n, 0);
        check("abort_mr_after", mr_n, 0);

        // Reset at cycle 17, then a full sequence
        st[0] = 1; ra[0] = 15'h1234;
        tick();
        for (int e = 1; e <= 17; e++) begin
            if (e == 17) rs[0] = 1;
            tick();
        end
        check("midreset_curRef", o_cr[0], 0);
        check("midreset_regWrite", o_rw[0], 0);
        check("midreset_busy", o_bz[0], 0);
        mr_n = 0;
        repeat (5) begin
            tick();
            if (o_mr[0]) mr_n++;
        end
        check("midreset_no_mr", mr_n, 0);
        st[0] = 1; ra[0] = 15'h0abc;
        mr_c = -1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (o_mr[0]) mr_c = c;
        end
        check("after_reset_mr_cycle", mr_c, 19);

        // Start and abort together in IDLE
        st[0] = 1; ab[0] = 1; ra[0] = 15'h0555;
        tick();
        check("start_abort_busy", o_bz[0], 0);
        check("start_abort_curRef", o_cr[0], 'h0abc);
        tick();
        check("start_abort_busy2", o_bz[0], 0);

        // Randomised traffic on both instances
        repeat (1500) begin
            for (int d = 0; d < 2; d++) begin
                st[d] = ($urandom_range(0, 7) == 0);
                ab[d] = ($urandom_range(0, 39) == 0);
                rs[d] = ($urandom_range(0, 149) == 0);
                ra[d] = 15'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
